// File: rtl/boot_load_ctrl.sv
// Boot image loader: header / base address / N data words, buffered handshaked memory writes.
// Optional trailing additive checksum word enabled by defining BOOT_LOAD_CSUM_EN.
module boot_load_ctrl #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter logic [15:0] MAGIC          = 16'hB007,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] pkt_data,
   input  logic                  pkt_valid,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   input  logic                  mem_ready,
   output logic                  cpu_rst_hold,
   output logic                  load_busy,
   output logic                  load_done,
   output logic                  load_error,
   output logic [2:0]            err_code
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_HDR_ADDR = 3'd1;
   localparam logic [2:0] S_DATA     = 3'd2;
`ifdef BOOT_LOAD_CSUM_EN
   localparam logic [2:0] S_CSUM     = 3'd3;
   localparam logic [2:0] E_CSUM     = 3'd5;
`endif
   localparam logic [2:0] S_DONE     = 3'd4;
   localparam logic [2:0] S_ERROR    = 3'd5;

   localparam logic [2:0] E_MAGIC    = 3'd1;
   localparam logic [2:0] E_ALIGN    = 3'd2;
   localparam logic [2:0] E_OVF      = 3'd3;
   localparam logic [2:0] E_TMO      = 3'd4;

   localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

   logic [2:0]            state, state_next;
   logic [15:0]           n_words, rx_count, wr_count;
   logic [DATA_WIDTH-1:0] fifo_mem [2];
   logic                  rd_ptr, wr_ptr;
   logic [1:0]            fifo_cnt, cnt_after_pop, cnt_next;
   logic [31:0]           tmo_cnt;
   logic                  pop, push, rx_all, drained, tmo_run, tmo_hit, err_fire;
   logic [2:0]            err_val;
`ifdef BOOT_LOAD_CSUM_EN
   logic [31:0]           csum_sum;
   logic                  csum_rcvd;
`endif

   always_comb begin
      pop           = mem_we && mem_ready;
      rx_all        = (rx_count == n_words);
      push          = pkt_valid && (state == S_DATA) && !rx_all;
      cnt_after_pop = fifo_cnt - {1'b0, pop};
      cnt_next      = cnt_after_pop + {1'b0, push};
      drained       = (wr_count == n_words) && (fifo_cnt == 2'd0);
      tmo_run       = (state == S_HDR_ADDR) || ((state == S_DATA) && !rx_all);
`ifdef BOOT_LOAD_CSUM_EN
      if ((state == S_CSUM) && !csum_rcvd) tmo_run = 1'b1;
`endif
      tmo_hit    = tmo_run && !pkt_valid && ((tmo_cnt + 32'd1) == TMO_LIMIT);
      state_next = state;
      err_fire   = 1'b0;
      err_val    = 3'd0;
      case (state)
         S_IDLE: begin
            if (pkt_valid) begin
               if (pkt_data[31:16] != MAGIC) begin
                  err_fire = 1'b1;
                  err_val  = E_MAGIC;
               end else begin
                  state_next = S_HDR_ADDR;
               end
            end
         end
         S_HDR_ADDR: begin
            if (pkt_valid) begin
               if (pkt_data[1:0] != 2'b00) begin
                  err_fire = 1'b1;
                  err_val  = E_ALIGN;
               end else if (n_words == 16'd0) begin
`ifdef BOOT_LOAD_CSUM_EN
                  state_next = S_CSUM;
`else
                  state_next = S_DONE;
`endif
               end else begin
                  state_next = S_DATA;
               end
            end else if (tmo_hit) begin
               err_fire = 1'b1;
               err_val  = E_TMO;
            end
         end
         S_DATA: begin
            // A pop in the same cycle frees a slot, so a push into a full buffer is still legal.
            if (push && (fifo_cnt == 2'd2) && !pop) begin
               err_fire = 1'b1;
               err_val  = E_OVF;
            end else if (tmo_hit) begin
               err_fire = 1'b1;
               err_val  = E_TMO;
            end else begin
`ifdef BOOT_LOAD_CSUM_EN
               if (push && ((rx_count + 16'd1) == n_words)) state_next = S_CSUM;
`else
               if (rx_all && drained) state_next = S_DONE;
`endif
            end
         end
`ifdef BOOT_LOAD_CSUM_EN
         S_CSUM: begin
            if (pkt_valid && !csum_rcvd) begin
               if (pkt_data != csum_sum) begin
                  err_fire = 1'b1;
                  err_val  = E_CSUM;
               end
            end else if (tmo_hit) begin
               err_fire = 1'b1;
               err_val  = E_TMO;
            end else if (csum_rcvd && drained) begin
               state_next = S_DONE;
            end
         end
`endif
         S_DONE, S_ERROR: begin
            if (start) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      if (err_fire) state_next = S_ERROR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         n_words   <= '0;
         rx_count  <= '0;
         wr_count  <= '0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         fifo_cnt  <= '0;
         tmo_cnt   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         err_code  <= '0;
`ifdef BOOT_LOAD_CSUM_EN
         csum_sum  <= '0;
         csum_rcvd <= 1'b0;
`endif
      end else begin
         state   <= state_next;
         tmo_cnt <= (tmo_run && !pkt_valid) ? tmo_cnt + 32'd1 : '0;
         if ((state == S_IDLE) && pkt_valid) begin
            n_words  <= pkt_data[15:0];
            rx_count <= '0;
            wr_count <= '0;
`ifdef BOOT_LOAD_CSUM_EN
            csum_sum  <= '0;
            csum_rcvd <= 1'b0;
`endif
         end
         if ((state == S_HDR_ADDR) && pkt_valid) mem_addr <= ADDR_WIDTH'(pkt_data);
         if (push) begin
            fifo_mem[wr_ptr] <= pkt_data;
            wr_ptr           <= ~wr_ptr;
            rx_count         <= rx_count + 16'd1;
`ifdef BOOT_LOAD_CSUM_EN
            csum_sum <= csum_sum + pkt_data;
`endif
         end
         if (pop) begin
            rd_ptr   <= ~rd_ptr;
            wr_count <= wr_count + 16'd1;
            mem_addr <= mem_addr + ADDR_WIDTH'(4);
         end
`ifdef BOOT_LOAD_CSUM_EN
         if ((state == S_CSUM) && pkt_valid) csum_rcvd <= 1'b1;
`endif
         // Head is re-presented every cycle; an empty buffer bypasses the incoming word straight out.
         fifo_cnt <= cnt_next;
         mem_we   <= (cnt_next != 2'd0);
         if (cnt_next != 2'd0)
            mem_wdata <= (cnt_after_pop == 2'd0) ? pkt_data : fifo_mem[rd_ptr ^ pop];
         if (((state == S_DONE) || (state == S_ERROR)) && start) err_code <= '0;
         if (err_fire) begin
            err_code <= err_val;
            mem_we   <= 1'b0;
            fifo_cnt <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
         end
      end
   end

   assign load_busy    = (state == S_HDR_ADDR) || (state == S_DATA)
`ifdef BOOT_LOAD_CSUM_EN
                       || (state == S_CSUM)
`endif
                       ;
   assign load_done    = (state == S_DONE);
   assign load_error   = (state == S_ERROR);
   assign cpu_rst_hold = (state != S_DONE);

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Directed bench for boot_load_ctrl: cycle vector table plus hand sequences for multi-cycle corners.
module tb_boot_load_ctrl;
   localparam int unsigned TMO = 100;
`ifdef BOOT_LOAD_CSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, start, pkt_valid, mem_ready;
   logic [31:0] pkt_data, mem_addr, mem_wdata;
   logic        mem_we, cpu_rst_hold, load_busy, load_done, load_error;
   logic [2:0]  err_code;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   boot_load_ctrl #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .MAGIC(16'hB007),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
      .cpu_rst_hold(cpu_rst_hold), .load_busy(load_busy), .load_done(load_done),
      .load_error(load_error), .err_code(err_code)
   );

   typedef struct {
      bit          st;
      bit          pv;
      logic [31:0] d;
      bit          rdy;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          busy, done, err, hold;
      logic [2:0]  code;
   } vec_t;

   vec_t vt[15];

   // Address/data only matter while a write is requested.
   function automatic logic [71:0] pk(input bit we, input bit busy, input bit done, input bit err,
                                      input bit hold, input logic [2:0] code,
                                      input logic [31:0] a, input logic [31:0] w);
      return {we, busy, done, err, hold, code, (we ? a : 32'h0), (we ? w : 32'h0)};
   endfunction

   function automatic logic [71:0] obs();
      return pk(mem_we, load_busy, load_done, load_error, cpu_rst_hold, err_code, mem_addr, mem_wdata);
   endfunction

   function automatic vec_t mk(input bit st, input bit pv, input logic [31:0] d, input bit rdy,
                               input bit we, input logic [31:0] a, input logic [31:0] w,
                               input bit busy, input bit done, input bit err, input bit hold,
                               input logic [2:0] code);
      vec_t v;
      v.st = st; v.pv = pv; v.d = d; v.rdy = rdy; v.we = we; v.addr = a; v.wdata = w;
      v.busy = busy; v.done = done; v.err = err; v.hold = hold; v.code = code;
      return v;
   endfunction

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit s, input bit pv, input logic [31:0] d, input bit rdy);
      start = s; pkt_valid = pv; pkt_data = d; mem_ready = rdy;
      @(posedge clk);
      #1;
      start = 1'b0; pkt_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input int unsigned budget);
      int unsigned n = 0;
      while (!load_done && !load_error && n < budget) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
         n++;
      end
      check(name, 72'({load_done, load_error, cpu_rst_hold}), 72'(3'b100));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned errs;
      vt[0]  = mk(0, 1,       32'hB0070003, 1, 0, 0,          0,     1, 0, 0, 1, 0);
      vt[1]  = mk(0, 1,       32'h00000100, 1, 0, 0,          0,     1, 0, 0, 1, 0);
      vt[2]  = mk(0, 1,       32'h00000011, 1, 1, 32'h100,    32'h11, 1, 0, 0, 1, 0);
      vt[3]  = mk(0, 1,       32'h00000022, 1, 1, 32'h104,    32'h22, 1, 0, 0, 1, 0);
      vt[4]  = mk(0, 1,       32'h00000033, 1, 1, 32'h108,    32'h33, 1, 0, 0, 1, 0);
      vt[5]  = mk(0, CSUM_ON, 32'h00000066, 1, 0, 0,          0,     1, 0, 0, 1, 0);
      vt[6]  = mk(0, 0,       32'h0,        1, 0, 0,          0,     0, 1, 0, 0, 0);
      vt[7]  = mk(1, 0,       32'h0,        1, 0, 0,          0,     0, 0, 0, 1, 0);
      vt[8]  = mk(0, 1,       32'hDEAD0002, 1, 0, 0,          0,     0, 0, 1, 1, 1);
      vt[9]  = mk(0, 1,       32'hB0070001, 1, 0, 0,          0,     0, 0, 1, 1, 1);
      vt[10] = mk(1, 0,       32'h0,        1, 0, 0,          0,     0, 0, 0, 1, 0);
      vt[11] = mk(0, 1,       32'hB0070001, 1, 0, 0,          0,     1, 0, 0, 1, 0);
      vt[12] = mk(0, 1,       32'h00000102, 1, 0, 0,          0,     0, 0, 1, 1, 2);
      vt[13] = mk(1, 0,       32'h0,        1, 0, 0,          0,     0, 0, 0, 1, 0);
      vt[14] = mk(1, 0,       32'h0,        1, 0, 0,          0,     0, 0, 0, 1, 0);

      rst = 1'b1; start = 1'b0; pkt_valid = 1'b0; pkt_data = '0; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {mem_we, load_busy, load_done, load_error, cpu_rst_hold, err_code, mem_addr, mem_wdata},
            72'h08_0000_0000_0000_0000);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         drive(vt[i].st, vt[i].pv, vt[i].d, vt[i].rdy);
         check($sformatf("vec%0d", i), obs(),
               pk(vt[i].we, vt[i].busy, vt[i].done, vt[i].err, vt[i].hold, vt[i].code, vt[i].addr, vt[i].wdata));
      end

      // Full buffer plus same-cycle accept: push is legal.
      drive(0, 1, 32'hB0070003, 0);
      drive(0, 1, 32'h00000500, 0);
      drive(0, 1, 32'h000000A1, 0);
      check("first_write_latency", obs(), pk(1, 1, 0, 0, 1, 0, 32'h500, 32'hA1));
      drive(0, 1, 32'h000000A2, 0);
      check("stall_stable", obs(), pk(1, 1, 0, 0, 1, 0, 32'h500, 32'hA1));
      drive(0, 1, 32'h000000A3, 1);
      check("push_with_pop", obs(), pk(1, 1, 0, 0, 1, 0, 32'h504, 32'hA2));
      if (CSUM_ON) drive(0, 1, 32'h000001E6, 1);
      wait_done("push_with_pop_done", 20);
      drive(1, 0, 0, 1);

      // Overflow: third word into a stalled full buffer.
      drive(0, 1, 32'hB0070004, 0);
      drive(0, 1, 32'h00000600, 0);
      drive(0, 1, 32'h00000001, 0);
      drive(0, 1, 32'h00000002, 0);
      drive(0, 1, 32'h00000003, 0);
      check("overflow", obs(), pk(0, 0, 0, 1, 1, 3, 0, 0));
      drive(1, 0, 0, 1);

      // Timeout exactly TMO cycles after the last packet.
      drive(0, 1, 32'hB0070001, 1);
      drive(0, 1, 32'h00000700, 1);
      errs = 0;
      for (int i = 0; i < TMO - 1; i++) begin
         drive(0, 0, 0, 1);
         if (load_error) errs++;
      end
      check("timeout_not_early", 72'(errs), 72'(0));
      drive(0, 0, 0, 1);
      check("timeout", obs(), pk(0, 0, 0, 1, 1, 4, 0, 0));
      drive(1, 0, 0, 1);

      // Draining a stalled write never times out.
      drive(0, 1, 32'hB0070001, 0);
      drive(0, 1, 32'h00000800, 0);
      drive(0, 1, 32'h0000005A, 0);
      if (CSUM_ON) drive(0, 1, 32'h0000005A, 0);
      errs = 0;
      for (int i = 0; i < 150; i++) begin
         drive(0, 0, 0, 0);
         if (load_error) errs++;
      end
      check("drain_no_timeout", 72'(errs), 72'(0));
      check("drain_held", obs(), pk(1, 1, 0, 0, 1, 0, 32'h800, 32'h5A));
      wait_done("drain_done", 10);
      drive(1, 0, 0, 1);

      // Empty image.
      drive(0, 1, 32'hB0070000, 1);
      drive(0, 1, 32'h00000900, 1);
      if (CSUM_ON) drive(0, 1, 32'h00000000, 1);
      wait_done("n_zero", 5);
      drive(1, 0, 0, 1);

      // Reset in the middle of a pending write.
      drive(0, 1, 32'hB0070002, 0);
      drive(0, 1, 32'h00000A00, 0);
      drive(0, 1, 32'h00000077, 0);
      check("pending_before_rst", obs(), pk(1, 1, 0, 0, 1, 0, 32'hA00, 32'h77));
      rst = 1'b1;
      drive(0, 0, 0, 0);
      rst = 1'b0;
      check("mid_load_reset", obs(), pk(0, 0, 0, 0, 1, 0, 0, 0));

`ifdef BOOT_LOAD_CSUM_EN
      drive(0, 1, 32'hB0070002, 1);
      drive(0, 1, 32'h00000400, 1);
      drive(0, 1, 32'h00000001, 1);
      drive(0, 1, 32'h00000002, 1);
      drive(0, 1, 32'h00000003, 1);
      wait_done("csum_good", 10);
      drive(1, 0, 0, 1);

      drive(0, 1, 32'hB0070002, 1);
      drive(0, 1, 32'h00000400, 1);
      drive(0, 1, 32'h00000001, 1);
      drive(0, 1, 32'h00000002, 1);
      drive(0, 1, 32'h00000004, 1);
      check("csum_bad", obs(), pk(0, 0, 0, 1, 1, 5, 0, 0));
      drive(1, 0, 0, 1);

      drive(0, 1, 32'hB0070002, 1);
      drive(0, 1, 32'hFFFFFFFC, 1);
      drive(0, 1, 32'h0000000A, 1);
      check("wrap_first", obs(), pk(1, 1, 0, 0, 1, 0, 32'hFFFFFFFC, 32'hA));
      drive(0, 1, 32'h0000000B, 1);
      check("wrap_second", obs(), pk(1, 1, 0, 0, 1, 0, 32'h00000000, 32'hB));
      drive(0, 1, 32'h00000015, 1);
      wait_done("wrap_done", 10);
      drive(1, 0, 0, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/boot_load_ctrl.md
Name: boot_load_ctrl

Overview:
- Sequences the byte-to-word packet builder output into instruction memory at boot.
- Parses a 3-part stream: header word, base-address word, N data words, plus an optional checksum word.
- Issues handshaked memory writes through a 2-entry buffer.
- Holds the CPU in reset until the image is loaded, and reports done or error.

Parameters:
- DATA_WIDTH, 32, packet/memory data width. Must be 32.
- ADDR_WIDTH, 32, memory byte-address width.
- MAGIC, 16'hB007, required value of header[31:16].
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between expected packets before a timeout error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; re-arms the loader from DONE or ERROR
- pkt_data  in  DATA_WIDTH  assembled word from the packet builder
- pkt_valid  in  1  one-cycle strobe per word; no backpressure possible
- mem_addr  out  ADDR_WIDTH  write byte address
- mem_wdata  out  DATA_WIDTH  write data
- mem_we  out  1  write request; held until accepted
- mem_ready  in  1  write accept; transfer occurs when mem_we && mem_ready
- cpu_rst_hold  out  1  CPU reset hold
- load_busy  out  1  high in HDR_ADDR, DATA, CSUM
- load_done  out  1  sticky success flag
- load_error  out  1  sticky error flag
- err_code  out  3  error cause, valid while load_error is high

Behaviour:
- Reset values: state=IDLE, cpu_rst_hold=1, mem_we=0, mem_addr=0, mem_wdata=0, load_busy=0, load_done=0, load_error=0, err_code=0. Buffer is emptied.
- Reset asserted mid-load abandons everything at once, including any pending write. mem_we is 0 on the next cycle.
- IDLE: waits for pkt_valid. Header is checked as follows:
  - header[31:16] != MAGIC: go to ERROR, err_code=1.
  - Otherwise latch N = header[15:0] and go to HDR_ADDR.
- HDR_ADDR: on pkt_valid, the word is the base address.
  - addr[1:0] != 0: go to ERROR, err_code=2.
  - Otherwise latch the address.
  - N=0: go to CSUM if the feature is enabled, else go directly to DONE.
  - N>0: go to DATA.
- DATA: each pkt_valid pushes the word into a 2-entry FIFO and increments rx_count.
  - When rx_count reaches N, stop accepting data: go to CSUM (feature on), or stay in DATA draining (feature off).
- Write engine: when the FIFO is non-empty and no write is pending, present the head entry on the next cycle.
  - Best-case latency is pkt_valid at cycle t, mem_we=1 at cycle t+1.
  - mem_addr and mem_wdata stay stable while mem_we && !mem_ready.
  - On accept: pop the entry, add 4 to the address (wraps modulo 2^ADDR_WIDTH), increment wr_count.
  - Back-to-back writes are allowed: mem_we stays high if the next entry is present.
- Overflow: pkt_valid arrives with the FIFO holding 2 entries and no pop in the same cycle. Go to ERROR, err_code=3. A pop in the same cycle makes the push legal.
- Timeout:
  - The counter runs only while a packet is still expected: HDR_ADDR, DATA with rx_count<N, and CSUM before the checksum is received.
  - The counter clears on every pkt_valid.
  - Reaching TIMEOUT_CYCLES: go to ERROR, err_code=4.
  - No timeout while only draining writes or while in IDLE.
- Completion: wr_count==N, FIFO empty, and checksum received and good (if the feature is on). Go to DONE on the next cycle:
  - cpu_rst_hold=0, load_done=1, load_busy=0.
- ERROR entry:
  - mem_we drops the next cycle and the FIFO is flushed.
  - cpu_rst_hold stays 1, load_error=1, load_busy=0.
  - err_code holds the first error only.
- DONE and ERROR: pkt_valid is ignored. start moves to IDLE and clears load_done, load_error and err_code; cpu_rst_hold returns to 1.
- start in any other state is ignored.
- Simultaneous events: if an error condition and completion occur in the same cycle, the error wins.

Optional Feature:
- Macro: BOOT_LOAD_CSUM_EN.
- Defined:
  - A running 32-bit sum (mod 2^32) is accumulated over received data words.
  - CSUM state waits for one more word.
  - Mismatch: go to ERROR, err_code=5.
  - Match: DONE once writes drain. The checksum word may arrive before writes finish.
- Undefined:
  - No CSUM state and no accumulator; completion depends on wr_count==N only.
  - err_code 5 is never produced.

Test Plan:
- Feature off, mem_ready tied 1. Send 0xB0070003, 0x00000100, 0x11, 0x22, 0x33 -> writes (0x100,0x11), (0x104,0x22), (0x108,0x33). Then load_done=1, cpu_rst_hold=0.
- Header 0xDEAD0002 -> load_error=1, err_code=1, no mem_we. Then start pulse -> IDLE, flags cleared, cpu_rst_hold=1.
- Header OK, address 0x00000102 -> err_code=2.
- mem_ready held 0. Send 3 data words on consecutive cycles -> third word gives err_code=3 and mem_we drops next cycle.
- TIMEOUT_CYCLES=100. Send header and address, then no packets -> err_code=4 exactly 100 cycles after the last pkt_valid.
- Feature on. Data 0x1, 0x2 with checksum 0x3 -> DONE. Checksum 0x4 -> err_code=5. Address 0xFFFFFFFC with N=2 -> second write goes to 0x00000000.
